lcd_count_writer: RTL and testbench
===================================

# lcd_count_writer

Formats a 32-bit unsigned count, such as the capacitive-sensor final charge count, as decimal ASCII and streams it to the character LCD controller. It sits directly upstream of the `lcd` controller and drives its `lcd_reset`, `lcd_write_en` and `lcd_write_data` inputs. Each frame clears the display, converts the sampled value with a sequential double-dabble, then writes one character per write slot.

## Interface
- `DIGITS`, 10: characters written per frame; 10 covers the full 32-bit range.
- `CLEAR_CYCLES`, 16: cycles `lcd_reset` is held high at frame start.
- `WRITE_GAP`, 100000: cycles from one write strobe to the next (2 ms at 50 MHz); minimum 2.
- `REFRESH_CYCLES`, 5000000: auto-start period in cycles; 0 disables auto-start.
- `clock`, in, 1: 50 MHz system clock (`CLOCK_50`).
- `resetn`, in, 1: asynchronous, active-low reset.
- `value`, in, 32: unsigned count to display; sampled only in CAPTURE.
- `start`, in, 1: single-cycle frame request; ignored while `busy`.
- `lcd_reset`, out, 1: active-high clear to the `lcd` controller.
- `lcd_write_en`, out, 1: one-cycle character strobe.
- `lcd_write_data`, out, 8: ASCII character, valid while `lcd_write_en` is high.
- `busy`, out, 1: high from CAPTURE through the last GAP.
- `done`, out, 1: one-cycle pulse at the end of a frame.

## Operation
- Reset values:
  - `lcd_reset`=1, `lcd_write_en`=0, `lcd_write_data`=8'h00, `busy`=0, `done`=0.
  - FSM in IDLE; refresh counter at 0.
- Trigger = `start` OR refresh tick. The refresh counter counts 0..`REFRESH_CYCLES`-1 continuously while not `busy` and ticks at wrap.
- FSM states:
  - IDLE: `lcd_reset`=0. On trigger, go to CAPTURE.
  - CAPTURE: latch `value` into a shift register, clear the BCD register (`4*DIGITS` bits) and the iteration counter. `busy`=1. Go to CONVERT.
  - CONVERT: one double-dabble iteration per cycle. Add 3 to each BCD nibble ≥5, then shift {bcd, bin} left by 1. Exactly 32 iterations, then go to CLEAR.
  - CLEAR: `lcd_reset`=1 for `CLEAR_CYCLES` cycles, then go to WRITE with digit index = `DIGITS`-1 (most significant digit).
  - WRITE: `lcd_write_en`=1 for one cycle. `lcd_write_data` = 8'h30 + nibble[index], or 8'h20 if blanked (see Configuration). Go to GAP.
  - GAP: hold `lcd_write_en`=0 and wait `WRITE_GAP`-1 cycles. If index = 0, go to FIN; otherwise decrement index and go to WRITE.
  - FIN: `done`=1 for one cycle, `busy`=0, refresh counter cleared. Go to IDLE.
- `lcd_write_data` holds its last value between strobes.
- Changes on `value` after CAPTURE have no effect on the frame in progress.
- A trigger in any state other than IDLE is dropped, not queued. A refresh tick and `start` in the same cycle produce one frame.
- Asserting `resetn` mid-frame immediately forces all outputs to their reset values and aborts the frame. No partial write strobe is emitted.

## Timing
- Trigger at cycle T: CAPTURE at T+1, CONVERT T+2..T+33, CLEAR T+34..T+33+`CLEAR_CYCLES`.
- First `lcd_write_en` at T+34+`CLEAR_CYCLES`.
- Strobe k (k = 0..`DIGITS`-1) at T+34+`CLEAR_CYCLES`+k·`WRITE_GAP`.
- `done` pulses `WRITE_GAP` cycles after the last strobe.
- Default frame length is about 1,000,050 cycles (20 ms), well inside the 100 ms refresh period.

## Configuration
- `LEAD_ZERO_BLANK_EN` defined:
  - Leading zero digits are sent as space (8'h20).
  - The least significant digit is never blanked, so value 0 shows a single '0' in the last position.
  - Blanking stops at the first nonzero digit; zeros after it are printed.
- Undefined: every digit is sent as ASCII, leading zeros included.
- Frame length and strobe count are identical in both builds.

## Test plan
- `LEAD_ZERO_BLANK_EN` defined, `value`=56876, `start` pulse → 10 strobes carrying "     56876" (five 8'h20 then 8'h35,8'h36,8'h38,8'h37,8'h36), then one `done` pulse.
- Macro undefined, `value`=56876 → "0000056876"; first strobe exactly 34+`CLEAR_CYCLES` cycles after `start`.
- `value`=32'hFFFFFFFF → "4294967295". `value`=0 with macro → nine spaces then '0'. `value`=0 without macro → "0000000000".
- Change `value` to 123 and pulse `start` again midway through WRITE/GAP → current frame still shows the original digits, the second `start` is ignored, and exactly 10 strobes occur.
- `REFRESH_CYCLES`=1000, `WRITE_GAP`=4, no `start` → frames repeat automatically; the gap from `done` to the next CAPTURE is 1000 cycles.
- Assert `resetn` low during GAP → outputs take reset values asynchronously. After release with no trigger, no strobe occurs; a new `start` produces a complete, correct frame.

Source files
------------

// File: rtl/lcd_count_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_count_writer
// Purpose  : Converts a 32-bit unsigned count to decimal ASCII and streams it
//            to a character LCD controller. Each frame does the following:
//              1. Samples the input value.
//              2. Converts it with a serial double-dabble (32 cycles).
//              3. Pulses the controller clear for CLEAR_CYCLES.
//              4. Writes DIGITS characters, most significant digit first,
//                 one every WRITE_GAP cycles.
// Ports    : clock          - system clock
//            resetn         - asynchronous active-low reset
//            value[31:0]    - count to display, sampled at frame start
//            start          - single-cycle frame request (ignored when busy)
//            lcd_reset      - active-high clear to the LCD controller
//            lcd_write_en   - one-cycle character strobe
//            lcd_write_data - ASCII character, held between strobes
//            busy           - frame in progress
//            done           - one-cycle end-of-frame pulse
// Options  : LEAD_ZERO_BLANK_EN - when defined, leading zero digits are sent
//            as spaces. The last digit is never blanked.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_count_writer #(
  parameter int DIGITS         = 10,
  parameter int CLEAR_CYCLES   = 16,
  parameter int WRITE_GAP      = 100000,
  parameter int REFRESH_CYCLES = 5000000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] value,
  input  logic        start,
  output logic        lcd_reset,
  output logic        lcd_write_en,
  output logic [7:0]  lcd_write_data,
  output logic        busy,
  output logic        done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_BCD_W   = 4 * DIGITS;
  localparam int c_IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_TMR_MAX = (WRITE_GAP > CLEAR_CYCLES) ?
                             ((WRITE_GAP > 32) ? WRITE_GAP : 32) :
                             ((CLEAR_CYCLES > 32) ? CLEAR_CYCLES : 32);
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

  localparam logic [c_TMR_W-1:0] c_CONV_LAST = c_TMR_W'(31);
  localparam logic [c_TMR_W-1:0] c_CLR_LAST  = c_TMR_W'(CLEAR_CYCLES - 1);
  // GAP lasts WRITE_GAP-1 cycles, so strobe-to-strobe spacing is WRITE_GAP.
  localparam logic [c_TMR_W-1:0] c_GAP_LAST  = c_TMR_W'(WRITE_GAP - 2);
  localparam logic [c_IDX_W-1:0] c_IDX_MSD   = c_IDX_W'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_CONVERT = 3'd2,
    S_CLEAR   = 3'd3,
    S_WRITE   = 3'd4,
    S_GAP     = 3'd5,
    S_FIN     = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // Registers / next-state signals
  // --------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [c_TMR_W-1:0]   timer_q, timer_d;
  logic [c_IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]          bin_q, bin_d;
  logic [c_BCD_W-1:0]   bcd_q, bcd_d;

  logic                 lcd_reset_q;
  logic                 write_en_q;
  logic [7:0]           data_q, data_d;
  logic                 busy_q;
  logic                 done_q;

  logic [c_BCD_W-1:0]   w_bcd_adj;
  logic                 w_trigger;
  logic                 w_tick;
  logic                 w_busy_now;
  logic                 w_load_char;
  logic [3:0]           w_nib;
  logic                 w_blank;

  // Frame states that hold the refresh counter at zero.
  assign w_busy_now = (state_q != S_IDLE) && (state_q != S_FIN);
  assign w_trigger  = start | w_tick;

  // --------------------------------------------------------------------------
  // Double-dabble correction: add 3 to every nibble >= 5 before the shift
  // --------------------------------------------------------------------------
  always_comb begin
    w_bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;

    case (state_q)
      S_IDLE: begin
        if (w_trigger) begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        bin_d   = value;
        bcd_d   = '0;
        timer_d = '0;
        state_d = S_CONVERT;
      end

      S_CONVERT: begin
        {bcd_d, bin_d} = {w_bcd_adj, bin_q} << 1;
        timer_d        = timer_q + 1'b1;
        if (timer_q == c_CONV_LAST) begin
          timer_d = '0;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == c_CLR_LAST) begin
          idx_d   = c_IDX_MSD;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        timer_d = '0;
        state_d = S_GAP;
      end

      S_GAP: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == c_GAP_LAST) begin
          if (idx_q == '0) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = S_WRITE;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Character selection. The character is computed on the cycle that enters
  // WRITE so it appears in the output register together with the strobe.
  // --------------------------------------------------------------------------
  assign w_load_char = (state_d == S_WRITE);

  always_comb begin
    w_nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(idx_d) == i) begin
        w_nib = bcd_q[4*i +: 4];
      end
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  // The blank flag stays set while every digit sent so far has been a
  // leading zero. It clears at the first nonzero digit.
  logic blank_q, blank_d;

  always_comb begin
    blank_d = blank_q;
    w_blank = 1'b0;
    if (state_q == S_CAPTURE) begin
      blank_d = 1'b1;
    end else if (w_load_char) begin
      w_blank = blank_q && (w_nib == 4'd0) && (idx_d != '0);
      blank_d = w_blank;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    data_d = data_q;
    if (w_load_char) begin
      data_d = w_blank ? 8'h20 : (8'h30 + {4'd0, w_nib});
    end
  end

  // --------------------------------------------------------------------------
  // Auto-refresh counter. It runs only in IDLE/FIN and restarts from zero at
  // FIN, so the next auto frame begins REFRESH_CYCLES after done.
  // --------------------------------------------------------------------------
  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      localparam int c_REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_CYCLES - 1);

      logic [c_REF_W-1:0] ref_cnt_q, ref_cnt_d;

      always_comb begin
        ref_cnt_d = ref_cnt_q + 1'b1;
        if (w_busy_now || (ref_cnt_q == c_REF_LAST)) begin
          ref_cnt_d = '0;
        end
      end

      assign w_tick = !w_busy_now && (ref_cnt_q == c_REF_LAST);

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          ref_cnt_q <= '0;
        end else begin
          ref_cnt_q <= ref_cnt_d;
        end
      end
    end else begin : g_no_refresh
      assign w_tick = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State and registered outputs. Outputs are derived from the next state so
  // they line up with the state they describe and reset asynchronously.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      lcd_reset_q <= 1'b1;
      write_en_q  <= 1'b0;
      data_q      <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      lcd_reset_q <= (state_d == S_CLEAR);
      write_en_q  <= w_load_char;
      data_q      <= data_d;
      busy_q      <= (state_d != S_IDLE) && (state_d != S_FIN);
      done_q      <= (state_d == S_FIN);
    end
  end

  assign lcd_reset      = lcd_reset_q;
  assign lcd_write_en   = write_en_q;
  assign lcd_write_data = data_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_count_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_count_writer
// Purpose  : Directed self-checking bench for lcd_count_writer. Instance A
//            runs with auto-refresh disabled for the start-driven frames.
//            Instance B runs with a short refresh period for the auto-frame
//            timing. Expected strings depend on LEAD_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_count_writer;

  localparam int CLR = 16;
  localparam int GAP = 4;
  localparam int DIG = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: start-driven ----------------
  logic        rstn_a;
  logic [31:0] val_a;
  logic        start_a;
  logic        lrst_a, we_a, busy_a, done_a;
  logic [7:0]  data_a;

  lcd_count_writer #(
    .DIGITS(DIG), .CLEAR_CYCLES(CLR), .WRITE_GAP(GAP), .REFRESH_CYCLES(0)
  ) u_dut_a (
    .clock(clk), .resetn(rstn_a), .value(val_a), .start(start_a),
    .lcd_reset(lrst_a), .lcd_write_en(we_a), .lcd_write_data(data_a),
    .busy(busy_a), .done(done_a)
  );

  // ---------------- instance B: auto-refresh ----------------
  logic        rstn_b;
  logic [31:0] val_b;
  logic        start_b;
  logic        lrst_b, we_b, busy_b, done_b;
  logic [7:0]  data_b;

  lcd_count_writer #(
    .DIGITS(DIG), .CLEAR_CYCLES(CLR), .WRITE_GAP(GAP), .REFRESH_CYCLES(1000)
  ) u_dut_b (
    .clock(clk), .resetn(rstn_b), .value(val_b), .start(start_b),
    .lcd_reset(lrst_b), .lcd_write_en(we_b), .lcd_write_data(data_b),
    .busy(busy_b), .done(done_b)
  );

  // ---------------- monitors ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] str_data [256];
  int         str_cyc  [256];
  int         n_str  = 0;
  int         n_done = 0;
  int         done_cyc = 0;

  always @(negedge clk) begin
    if (we_a) begin
      str_data[n_str % 256] <= data_a;
      str_cyc[n_str % 256]  <= cyc;
      n_str                 <= n_str + 1;
    end
    if (done_a) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  int   b_rise [8];
  int   b_done [8];
  int   nb_rise = 0;
  int   nb_done = 0;
  logic b_busy_prev = 1'b0;

  always @(negedge clk) begin
    b_busy_prev <= busy_b;
    if (busy_b && !b_busy_prev) begin
      b_rise[nb_rise % 8] <= cyc;
      nb_rise             <= nb_rise + 1;
    end
    if (done_b) begin
      b_done[nb_done % 8] <= cyc;
      nb_done             <= nb_done + 1;
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for the instance-A done counter to move past d0, bounded.
  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (n_done == d0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
  endtask

  // One frame on instance A. With mid set, value changes and start pulses
  // again after the third strobe; neither may affect the result.
  task automatic run_frame(input logic [31:0] v, input string exp, input string tag,
                           input bit mid);
    int s0, d0, t0, k;
    s0    = n_str;
    d0    = n_done;
    val_a = v;
    @(posedge clk); #1 start_a = 1'b1; t0 = cyc;
    @(posedge clk); #1 start_a = 1'b0;
    if (mid) begin
      k = 0;
      while (n_str - s0 < 3 && k < 500) begin
        @(posedge clk);
        k++;
      end
      #1 val_a = 32'd123; start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
    end
    wait_done(d0);
    // Long enough for a wrongly queued second frame to show its strobes.
    repeat (150) @(posedge clk);
    check($sformatf("%s strobes", tag), n_str - s0, DIG);
    check($sformatf("%s done", tag), n_done - d0, 1);
    for (int i = 0; i < DIG; i++) begin
      check($sformatf("%s ch%0d", tag, i), {24'd0, str_data[(s0 + i) % 256]}, {24'd0, exp[i]});
    end
    check($sformatf("%s first_lat", tag), str_cyc[s0 % 256] - t0, 34 + CLR);
    check($sformatf("%s last_lat", tag), str_cyc[(s0 + DIG - 1) % 256] - t0,
          34 + CLR + (DIG - 1) * GAP);
    check($sformatf("%s done_lat", tag), done_cyc - str_cyc[(s0 + DIG - 1) % 256], GAP);
  endtask

  // ---------------- stimulus ----------------
  string e_56876, e_ffff, e_zero, e_mixed;

  initial begin
    int s0, d0, k;

`ifdef LEAD_ZERO_BLANK_EN
    e_56876 = "     56876";
    e_ffff  = "4294967295";
    e_zero  = "         0";
    e_mixed = "   1000200";
`else
    e_56876 = "0000056876";
    e_ffff  = "4294967295";
    e_zero  = "0000000000";
    e_mixed = "0001000200";
`endif

    rstn_a  = 1'b0;
    rstn_b  = 1'b0;
    val_a   = 32'd0;
    start_a = 1'b0;
    val_b   = 32'd42;
    start_b = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst lcd_reset", lrst_a, 1);
    check("rst write_en", we_a, 0);
    check("rst data", data_a, 0);
    check("rst busy", busy_a, 0);
    check("rst done", done_a, 0);
    rstn_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle lcd_reset", lrst_a, 0);
    check("idle busy", busy_a, 0);

    // Main conversions.
    run_frame(32'd56876, e_56876, "v56876", 1'b0);
    run_frame(32'hFFFF_FFFF, e_ffff, "vmax", 1'b0);
    run_frame(32'd0, e_zero, "vzero", 1'b0);
    run_frame(32'd1000200, e_mixed, "vmixed", 1'b0);

    // Restart attempt and value change mid-frame.
    run_frame(32'd56876, e_56876, "vmid", 1'b1);

    // Asynchronous reset during GAP.
    s0    = n_str;
    val_a = 32'd56876;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    k = 0;
    while (n_str - s0 < 2 && k < 500) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    check("pre-rst busy", busy_a, 1);
    #2 rstn_a = 1'b0;
    #1;
    check("arst lcd_reset", lrst_a, 1);
    check("arst write_en", we_a, 0);
    check("arst data", data_a, 0);
    check("arst busy", busy_a, 0);
    check("arst done", done_a, 0);
    repeat (3) @(posedge clk);
    #1 rstn_a = 1'b1;
    s0 = n_str;
    d0 = n_done;
    repeat (200) @(posedge clk);
    check("post-rst strobes", n_str - s0, 0);
    check("post-rst done", n_done - d0, 0);
    check("post-rst busy", busy_a, 0);
    run_frame(32'd56876, e_56876, "after_rst", 1'b0);

    // Auto-refresh frames on instance B.
    @(posedge clk); #1 rstn_b = 1'b1;
    k = 0;
    while (nb_rise < 3 && k < 6000) begin
      @(posedge clk);
      k++;
    end
    check("auto frames", (nb_rise >= 3) ? 1 : 0, 1);
    check("auto gap1", b_rise[1] - b_done[0], 1000);
    check("auto gap2", b_rise[2] - b_done[1], 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
